// File: rtl/nn_fixed_pkg.sv
// Shared Q16.16 fixed-point types and helpers for the NN layers.
// Holds format defaults, FSM states, saturate/ReLU and flat-matrix indexing.
package nn_fixed_pkg;

  localparam int FX_WIDTH = 32;
  localparam int FX_FRAC  = 16;
  localparam int FX_GUARD = 8;
  localparam int FX_MAXW  = 128;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fsm_e;

  // Clamp a wide signed value to a w-bit signed range (w <= 64).
  function automatic logic signed [FX_MAXW-1:0] fx_sat(
    input logic signed [FX_MAXW-1:0] acc,
    input int                        w
  );
    logic signed [FX_MAXW-1:0] one;
    logic signed [FX_MAXW-1:0] hi;
    logic signed [FX_MAXW-1:0] lo;
    one = 1;
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    if (acc > hi)
      return hi;
    else if (acc < lo)
      return lo;
    return acc;
  endfunction

  function automatic logic signed [FX_MAXW-1:0] fx_relu(
    input logic signed [FX_MAXW-1:0] x,
    input logic                      en
  );
    return (en && (x < 0)) ? '0 : x;
  endfunction

  // W[i][j] occupies [msb -: w]; element [0][0] sits in the MSBs.
  function automatic int fx_w_msb(
    input int i, input int j,
    input int nin, input int nout, input int w
  );
    return (nin * nout - (i * nin + j)) * w - 1;
  endfunction

  // b[i] occupies [lsb +: w]; b[0] sits in the MSBs.
  function automatic int fx_b_lsb(
    input int i, input int nout, input int w
  );
    return (nout - 1 - i) * w;
  endfunction

endpackage

// File: rtl/fx_mac.sv
// Fixed-point multiply-accumulate: acc + ((a*b) >>> FRAC), sign-extended.
// Ports: i_a, i_b operands; i_acc running sum; o_sum result.
module fx_mac
  import nn_fixed_pkg::*;
#(
  parameter int WIDTH = FX_WIDTH,
  parameter int FRAC  = FX_FRAC,
  parameter int ACCW  = 2 * FX_WIDTH - FX_FRAC + FX_GUARD
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  input  logic signed [ACCW-1:0]  i_acc,
  output logic signed [ACCW-1:0]  o_sum
);

  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [2*WIDTH-1:0] w_shr;

  assign w_prod = i_a * i_b;
  // Arithmetic shift truncates toward -inf.
  assign w_shr  = w_prod >>> FRAC;
  assign o_sum  = i_acc + ACCW'(w_shr);

endmodule

// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully connected layer, one MAC per cycle, Q16.16.
// Ports: clk/rst_n; in_valid/in_ready/in_vec; out_valid/out_ready/out_vec; busy.
module fc_layer_seq
  import nn_fixed_pkg::*;
#(
  parameter int WIDTH = FX_WIDTH,
  parameter int FRAC  = FX_FRAC,
  parameter int NIN   = 2,
  parameter int NOUT  = 16,
  parameter int RELU  = 1,
  parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0,
  parameter logic [WIDTH*NOUT-1:0]     BIAS_FLAT = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [0:NIN-1][WIDTH-1:0]    in_vec,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [0:NOUT-1][WIDTH-1:0]   out_vec,
  output logic                         busy
);

  // Wide enough for the full shifted product plus guard bits,
  // so even full-scale operands saturate instead of wrapping.
  localparam int ACCW = 2 * WIDTH - FRAC + FX_GUARD;
  localparam int IW   = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int JW   = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int WFW  = $clog2(WIDTH * NIN * NOUT);
  localparam int BFW  = $clog2(WIDTH * NOUT);

  fsm_e r_state;
  fsm_e w_state_nxt;

  logic [IW-1:0]               r_i;
  logic [JW-1:0]               r_j;
  logic signed [ACCW-1:0]      r_acc;
  logic [0:NIN-1][WIDTH-1:0]   r_x;
  logic [0:NOUT-1][WIDTH-1:0]  r_out;
  logic                        r_in_ready;
  logic                        r_out_valid;
  logic                        r_busy;

  logic [WFW-1:0]              w_wofs;
  logic [BFW-1:0]              w_bofs;
  logic signed [WIDTH-1:0]     w_w;
  logic signed [WIDTH-1:0]     w_b;
  logic signed [WIDTH-1:0]     w_x;
  logic signed [ACCW-1:0]      w_base;
  logic signed [ACCW-1:0]      w_sum;
  logic [WIDTH-1:0]            w_res;
  logic                        w_last_i;
  logic                        w_last_j;

  assign w_wofs = WFW'(fx_w_msb(int'(r_i), int'(r_j),
                                NIN, NOUT, WIDTH));
  assign w_bofs = BFW'(fx_b_lsb(int'(r_i), NOUT, WIDTH));

  assign w_w = WEIGHTS_MATRIX_FLAT[w_wofs -: WIDTH];
  assign w_b = BIAS_FLAT[w_bofs +: WIDTH];
  assign w_x = r_x[r_j];

  assign w_last_i = (r_i == IW'(NOUT - 1));
  assign w_last_j = (r_j == JW'(NIN - 1));

  // Bias seeds the accumulator on the first input of each neuron.
  assign w_base = (r_j == '0) ? ACCW'(w_b) : r_acc;

  fx_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACCW  (ACCW)
  ) u_mac (
    .i_a   (w_w),
    .i_b   (w_x),
    .i_acc (w_base),
    .o_sum (w_sum)
  );

  assign w_res = WIDTH'(fx_relu(
                   fx_sat(FX_MAXW'(w_sum), WIDTH),
                   RELU != 0));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_state_nxt = CALC;
      CALC: if (w_last_i && w_last_j) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_i         <= '0;
      r_j         <= '0;
      r_acc       <= '0;
      r_x         <= '0;
      r_out       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt == CALC);
      if (r_state == IDLE && in_valid) begin
        r_x <= in_vec;
        r_i <= '0;
        r_j <= '0;
      end
      if (r_state == CALC) begin
        r_acc <= w_sum;
        if (w_last_j) begin
          r_out[r_i] <= w_res;
          r_j        <= '0;
          r_i        <= w_last_i ? '0 : r_i + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_vec   = r_out;

endmodule
